// File: rtl/mult_seq_nxn_if.sv
// Handshake/data bundle for mult_seq_nxn: start with operands in, busy/done/product out.
// Valid/ready semantics: start is a request qualified by the block being out of CALC;
// busy acts as "not ready", and done marks the single cycle where product is first valid.
interface mult_seq_nxn_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult_seq_nxn.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one DIGIT x DIGIT partial product per
// cycle, accumulated at its digit offset; i walks a-slices inside, j walks b-slices outside.
module mult_seq_nxn #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  mult_seq_nxn_if.slave     bus,
  output logic [1:0]        state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [CW-1:0]        i_cnt;
  logic [CW-1:0]        j_cnt;
  logic [2*WIDTH-1:0]   product_r;

  logic                 accept;
  logic                 last_iter;
  logic                 i_wrap;
  logic [DIGIT-1:0]     a_slice;
  logic [DIGIT-1:0]     b_slice;
  logic [2*DIGIT-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_shifted;

  // A new request is only taken when no multiplication is in flight.
  assign accept    = bus.start && (state != CALC);
  assign i_wrap    = (i_cnt == CW'(N - 1));
  assign last_iter = i_wrap && (j_cnt == CW'(N - 1));

  assign a_slice    = DIGIT'(a_reg >> (32'(i_cnt) * DIGIT));
  assign b_slice    = DIGIT'(b_reg >> (32'(j_cnt) * DIGIT));
  assign pp         = (2*DIGIT)'(a_slice) * (2*DIGIT)'(b_slice);
  assign pp_shifted = (2*WIDTH)'(pp) << ((32'(i_cnt) + 32'(j_cnt)) * DIGIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      product_r <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b;
      i_cnt     <= '0;
      j_cnt     <= '0;
      product_r <= '0;
    end else if (state == CALC) begin
      product_r <= product_r + pp_shifted;
      if (i_wrap) begin
        i_cnt <= '0;
        j_cnt <= j_cnt + CW'(1);
      end else begin
        i_cnt <= i_cnt + CW'(1);
      end
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = (state == DONE);
  assign bus.product = product_r;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Bench for mult_seq_nxn: three parameter sets (32/16, 16/4, 8/8) share clock and reset,
// checked every cycle against a cycle-count/arithmetic model plus hand-computed vectors.
module tb_mult_seq_nxn;

  logic        clk;
  logic        reset;
  logic        start_v   [3];
  logic [31:0] a_v       [3];
  logic [31:0] b_v       [3];
  logic        busy_v    [3];
  logic        done_v    [3];
  logic [63:0] product_v [3];
  logic [1:0]  state_dbg [3];

  int tests_run = 0;
  int fails     = 0;

  // Model state: cycles into CALC (0 = not calculating), expected done and product.
  int          m_cnt    [3];
  logic        m_done   [3];
  logic [63:0] m_prod   [3];
  logic [63:0] m_target [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 8;
    localparam int D = (g == 0) ? 16 : (g == 1) ? 4 : 8;
    mult_seq_nxn_if #(.WIDTH(W)) bus ();
    mult_seq_nxn #(.WIDTH(W), .DIGIT(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg[g])
    );
    assign bus.start    = start_v[g];
    assign bus.a        = a_v[g][W-1:0];
    assign bus.b        = b_v[g][W-1:0];
    assign busy_v[g]    = bus.busy;
    assign done_v[g]    = bus.done;
    assign product_v[g] = 64'(bus.product);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int iters(input int d);
    return (d == 0) ? 4 : (d == 1) ? 16 : 1;
  endfunction

  function automatic logic [63:0] ref_mul(input int d, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    m = (d == 0) ? 32'hFFFF_FFFF : (d == 1) ? 32'h0000_FFFF : 32'h0000_00FF;
    return {32'b0, a & m} * {32'b0, b & m};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        m_cnt[d]  <= 0;
        m_done[d] <= 1'b0;
        m_prod[d] <= '0;
      end else if (m_cnt[d] != 0) begin
        if (m_cnt[d] == iters(d)) begin
          m_cnt[d]  <= 0;
          m_done[d] <= 1'b1;
          m_prod[d] <= m_target[d];
        end else begin
          m_cnt[d]  <= m_cnt[d] + 1;
          m_done[d] <= 1'b0;
        end
      end else begin
        m_done[d] <= 1'b0;
        if (start_v[d]) begin
          m_cnt[d]    <= 1;
          m_prod[d]   <= '0;
          m_target[d] <= ref_mul(d, a_v[d], b_v[d]);
        end
      end
    end
  end

  // Product is compared whenever it is defined: cleared in the first CALC cycle, final/held otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d busy", d), 64'(busy_v[d]), 64'(m_cnt[d] != 0));
        chk($sformatf("d%0d done", d), 64'(done_v[d]), 64'(m_done[d]));
        if (busy_v[d] && done_v[d]) chk($sformatf("d%0d busy_and_done", d), 64'd1, 64'd0);
        if (m_cnt[d] <= 1) chk($sformatf("d%0d product", d), product_v[d], m_prod[d]);
      end
    end
  end

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output logic [63:0] prod);
    int guard;
    a_v[d]     = a;
    b_v[d]     = b;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    busy_cycles = 0;
    guard = 0;
    while (!done_v[d] && guard < 64) begin
      if (busy_v[d]) busy_cycles++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) chk($sformatf("d%0d done_timeout", d), 64'd1, 64'd0);
    prod = product_v[d];
    @(negedge clk);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          bc;
    logic [63:0] p;
    int          last_done;
    int          ndone;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      a_v[d]     = '0;
      b_v[d]     = '0;
    end
    #1;
    chk("reset busy", 64'(busy_v[0]), 64'd0);
    chk("reset done", 64'(done_v[0]), 64'd0);
    chk("reset product", product_v[0], 64'd0);
    chk("reset state", 64'(state_dbg[0]), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vecs.push_back('{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4});
    vecs.push_back('{0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 4});
    vecs.push_back('{0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 4});
    vecs.push_back('{0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 4});
    vecs.push_back('{0, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 4});
    vecs.push_back('{0, 32'hFFFF_0000, 32'h0000_FFFF, 64'h0000_FFFE_0001_0000, 4});
    vecs.push_back('{1, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 16});
    vecs.push_back('{1, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, 16});
    vecs.push_back('{2, 32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_FE01, 1});
    vecs.push_back('{2, 32'h0000_0010, 32'h0000_000F, 64'h0000_0000_0000_00F0, 1});

    foreach (vecs[k]) begin
      run_op(vecs[k].d, vecs[k].a, vecs[k].b, bc, p);
      chk($sformatf("vec%0d product", k), p, vecs[k].exp);
      chk($sformatf("vec%0d model", k), m_prod[vecs[k].d], vecs[k].exp);
      chk($sformatf("vec%0d busy_cycles", k), 64'(bc), 64'(vecs[k].busy));
    end

    // Product must stay put through IDLE.
    repeat (3) @(negedge clk);
    chk("hold in idle", product_v[2], 64'h0000_0000_0000_00F0);

    // Start held high; operands scrambled every cycle while calculating.
    a_v[0]     = 32'h0000_0003;
    b_v[0]     = 32'h0000_0005;
    start_v[0] = 1'b1;
    last_done  = -1;
    ndone      = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c == 0) chk("b2b cleared", product_v[0], 64'd0);
      if (done_v[0]) begin
        if (last_done >= 0) chk("b2b spacing", 64'(c - last_done), 64'd5);
        if (ndone == 0) chk("b2b first product", product_v[0], 64'd15);
        last_done = c;
        ndone++;
      end
      a_v[0] = $urandom;
      b_v[0] = $urandom;
    end
    start_v[0] = 1'b0;
    chk("b2b done count", 64'(ndone), 64'd4);
    repeat (8) @(negedge clk);

    // Reset in the second CALC cycle, then a clean operation.
    a_v[0]     = 32'h0005_0003;
    b_v[0]     = 32'h0007_0002;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 64'(busy_v[0]), 64'd0);
    chk("abort done", 64'(done_v[0]), 64'd0);
    chk("abort product", product_v[0], 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    run_op(0, 32'h0005_0003, 32'h0007_0002, bc, p);
    chk("post reset product", p, 64'h0000_0023_001F_0006);

    // Random operands, each checked against plain a*b.
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 150; r++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = $urandom;
        rb = (r % 10 == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 32'hFFFF_FFFF));
        run_op(d, ra, rb, bc, p);
        chk($sformatf("rand d%0d", d), p, ref_mul(d, ra, rb));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
